icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the datapath fetch stage and the memory controller. Serves datapath instruction reads from 16 one-word frames. On a miss it issues a single-word refill over the controller's instruction port (iREN/iaddr/iwait/iload). Instruction requests are the lowest-priority requester at the controller, so refills can be stalled indefinitely by data traffic.

## Interface
Parameters:
- FRAMES, 16: number of one-word frames; power of two; index width IW = log2(FRAMES) = 4.

Ports (reset is asynchronous and active-high):
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- imemREN  in  1  datapath instruction read request
- imemaddr  in  32  datapath byte address; bits [1:0] ignored
- iflush  in  1  invalidate all frames (halt / self-modifying-code flush)
- ihit  out  1  imemload valid this cycle
- imemload  out  32  instruction word to datapath
- iREN  out  1  refill read request to memory controller
- iaddr  out  32  refill word address, bits [1:0] = 0
- iwait  in  1  controller stall; 0 = iload valid this cycle
- iload  in  32  refill data from controller
- hit_cnt  out  32  saturating count of hits
- miss_cnt  out  32  saturating count of misses

## Operation
- Address split: tag = imemaddr[31:IW+2] (26 bits), index = imemaddr[IW+1:2], offset = imemaddr[1:0] (ignored).
- Frame storage: valid[FRAMES], tag[FRAMES][26], data[FRAMES][32]. Reset and iflush clear all valid bits; tag/data need no reset.
- Hit: imemREN & valid[index] & tag match. ihit = 1 and imemload = data[index] combinationally, in state IDLE only.
- FSM states:
  - IDLE: on imemREN & miss, latch {tag,index} into miss_addr, increment miss_cnt, go to FETCH. On hit, increment hit_cnt, stay.
  - FETCH: iREN = 1, iaddr = {miss_addr, 2'b00}. While iwait = 1, hold. When iwait = 0: write valid = 1, tag, data = iload into frame miss_addr.index; go to IDLE.
- Outputs when not hitting: ihit = 0, imemload = 0. iREN = 0 outside FETCH; iaddr = 0 outside FETCH.
- The refill always targets the latched miss_addr. If the datapath changes imemaddr during FETCH (e.g. a squash), the refill still completes. The new address is looked up in IDLE afterwards.
- imemREN deasserted during FETCH does not abort the refill.
- iflush has priority over everything:
  - In any state, clears all valid bits next edge and forces IDLE.
  - A FETCH in progress is abandoned (iREN drops next cycle) and no frame is written, even if iwait = 0 in the same cycle.
  - ihit is forced 0 in any cycle where iflush = 1.
- Counters saturate at 32'hFFFF_FFFF and clear only on RST; iflush does not clear them.

## Timing
- Reset values: state IDLE, all valid = 0, ihit 0, imemload 0, iREN 0, iaddr 0, hit_cnt 0, miss_cnt 0.
- Hit latency: 0 cycles (same cycle as request).
- Miss latency, with the controller answering in the k-th FETCH cycle (k ≥ 1):
  - cycle 0: miss detected, ihit 0.
  - cycles 1..k: FETCH, with fill on the edge ending cycle k.
  - cycle k+1: IDLE hit, ihit 1.
  - Minimum miss-to-hit is 2 cycles after the miss cycle.
- iREN stays asserted continuously through FETCH until the iwait = 0 cycle. It never toggles while waiting.
- RST asserted mid-FETCH: iREN drops asynchronously, valid bits clear, and no partial frame remains valid.
- Index aliasing: addresses differing only in tag evict each other. There is no replacement choice.

## Test plan
- Reset, then imemREN = 1, imemaddr = 0x0000_0040, iwait = 1 for 3 FETCH cycles then 0 with iload = 0x2400_0001.
  - Required: ihit 0 until the cycle after fill, then ihit 1 and imemload = 0x2400_0001; miss_cnt 1, hit_cnt 1.
- Conflict: fill 0x0000_0040, then request 0x0000_0080 (same index 0, different tag).
  - Required: miss and refill with iaddr = 0x0000_0080.
  - A subsequent request to 0x40 misses again; miss_cnt 3.
- Address change mid-FETCH: miss on 0x44; switch imemaddr to 0x100 while iwait = 1; complete with iload = 0xAAAA_AAAA.
  - Required: frame 1 holds 0xAAAA_AAAA with tag of 0x44.
  - The next cycle misses on 0x100 (iaddr = 0x100).
- iflush in the same cycle as iwait = 0 during FETCH.
  - Required: no frame written, next state IDLE, iREN 0 next cycle.
  - Re-request of the same address misses.
- Async reset asserted mid-FETCH, between clock edges.
  - Required: iREN/iaddr go to 0 immediately; counters 0.
  - After release, previously filled addresses miss.
- Byte offset: fill 0x0000_0040, then request 0x0000_0043.
  - Required: hit, same word.

Source files
------------

// File: rtl/icache_if.sv
// Fetch-side request/response and controller refill signals of the instruction cache.
// The slave modport is the cache; the master modport is the datapath/controller side.
interface icache_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        iflush;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   modport slave (
      input  imemREN, imemaddr, iflush, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

   modport master (
      output imemREN, imemaddr, iflush, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one word per frame, single-word refill
// from the memory controller; iflush invalidates everything and abandons a refill.
module icache #(
   parameter int FRAMES = 16
) (
   input  logic        CLK,
   input  logic        RST,
   icache_if.slave     bus,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);
   localparam int IW = $clog2(FRAMES);
   localparam int TW = 30 - IW;

   typedef enum logic {IDLE, FETCH} state_e;

   state_e            state_q, state_d;
   logic [FRAMES-1:0] valid_q, valid_d;
   logic [TW-1:0]     tag_q  [FRAMES];
   logic [31:0]       data_q [FRAMES];
   logic [29:0]       miss_q, miss_d;
   logic [31:0]       hit_cnt_q, hit_cnt_d;
   logic [31:0]       miss_cnt_q, miss_cnt_d;

   logic [TW-1:0] req_tag;
   logic [IW-1:0] req_idx;
   logic [IW-1:0] fill_idx;
   logic          hit;
   logic          fill;
   logic          unused_offset;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   assign req_tag       = bus.imemaddr[31:IW+2];
   assign req_idx       = bus.imemaddr[IW+1:2];
   assign fill_idx      = miss_q[IW-1:0];
   assign unused_offset = ^bus.imemaddr[1:0];

   // Hits are only served from IDLE and are masked by a flush in the same cycle.
   assign hit = (state_q == IDLE) && bus.imemREN && !bus.iflush &&
                valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      miss_d     = miss_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      fill       = 1'b0;
      case (state_q)
         IDLE: begin
            if (hit) begin
               hit_cnt_d = sat_inc(hit_cnt_q);
            end else if (bus.imemREN && !bus.iflush) begin
               miss_d     = bus.imemaddr[31:2];
               miss_cnt_d = sat_inc(miss_cnt_q);
               state_d    = FETCH;
            end
         end
         FETCH: begin
            if (!bus.iwait && !bus.iflush) begin
               fill              = 1'b1;
               valid_d[fill_idx] = 1'b1;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (bus.iflush) begin
         valid_d = '0;
         state_d = IDLE;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         miss_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         miss_q     <= miss_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // Tag/data arrays are guarded by valid_q, so they carry no reset.
   always_ff @(posedge CLK) begin
      if (fill) begin
         tag_q[fill_idx]  <= miss_q[29:IW];
         data_q[fill_idx] <= bus.iload;
      end
   end

   assign bus.ihit     = hit;
   assign bus.imemload = hit ? data_q[req_idx] : '0;
   assign bus.iREN     = (state_q == FETCH);
   assign bus.iaddr    = (state_q == FETCH) ? {miss_q, 2'b00} : '0;
   assign hit_cnt      = hit_cnt_q;
   assign miss_cnt     = miss_cnt_q;
endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache: a word-level residency model predicts hit/miss,
// latency and data; a negedge monitor pops expected words whenever ihit is presented.
module tb_icache;
   logic        clk;
   logic        RST;
   logic [31:0] hit_cnt, miss_cnt;

   icache_if bus();

   icache dut (
      .CLK      (clk),
      .RST      (RST),
      .bus      (bus),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [31:0] q [$];
   logic [31:0] mem [logic [29:0]];
   logic [29:0] resident [int];
   int          m_hit = 0, m_miss = 0;
   int          fixed_lat = -1;
   int          cur_lat = 0;
   int          fcnt = 0;

   function automatic logic [31:0] mem_word(input logic [29:0] wa);
      if (!mem.exists(wa)) mem[wa] = $urandom;
      return mem[wa];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_cnt(input string name);
      @(negedge clk);
      chk({name, "_hits"}, hit_cnt, m_hit);
      chk({name, "_misses"}, miss_cnt, m_miss);
   endtask

   // Memory controller: answers each refill after cur_lat stalled FETCH cycles.
   always @(posedge clk) begin
      #1;
      if (RST || !bus.iREN) begin
         fcnt      = 0;
         bus.iwait = 1'b1;
         bus.iload = $urandom;
      end else begin
         if (fcnt == 0) cur_lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
         bus.iwait = (fcnt < cur_lat);
         bus.iload = bus.iwait ? $urandom : mem_word(bus.iaddr[31:2]);
         fcnt++;
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!RST) begin
         if (bus.ihit) begin
            if (q.size() == 0) begin
               chk("unexpected_hit", 32'd1, 32'd0);
            end else begin
               chk("hit_data", bus.imemload, q.pop_front());
            end
         end else begin
            chk("idle_load_zero", bus.imemload, 32'd0);
         end
      end
   end

   task automatic fetch(input logic [31:0] addr);
      logic [29:0] wa;
      bit          exp_hit;
      int          n;
      wa      = addr[31:2];
      exp_hit = resident.exists(int'(wa[3:0])) && (resident[int'(wa[3:0])] == wa);
      q.push_back(mem_word(wa));
      m_hit++;
      if (!exp_hit) m_miss++;
      tick();
      bus.imemREN  = 1'b1;
      bus.imemaddr = addr;
      n = 0;
      @(negedge clk);
      while (!bus.ihit && n < 100) begin
         if (n == 1) begin
            chk("refill_iren", bus.iREN, 1'b1);
            chk("refill_iaddr", bus.iaddr, {wa, 2'b00});
         end else if (n > 1) begin
            chk("iren_held", bus.iREN, 1'b1);
         end
         n++;
         @(negedge clk);
      end
      chk("latency", n, exp_hit ? 0 : cur_lat + 2);
      resident[int'(wa[3:0])] = wa;
      tick();
      bus.imemREN = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] a;
      RST          = 1'b1;
      bus.imemREN  = 1'b0;
      bus.imemaddr = '0;
      bus.iflush   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ihit", bus.ihit, 0);
      chk("rst_iren", bus.iREN, 0);
      chk("rst_iaddr", bus.iaddr, 0);
      tick();
      RST = 1'b0;
      chk_cnt("rst");

      // First miss: three stalled FETCH cycles, then data.
      mem[30'h10] = 32'h2400_0001;
      fixed_lat   = 3;
      fetch(32'h0000_0040);
      chk_cnt("first_miss");
      fetch(32'h0000_0040);
      chk_cnt("first_rehit");

      // Index conflict and byte offset.
      fixed_lat = 1;
      fetch(32'h0000_0080);
      fetch(32'h0000_0040);
      chk_cnt("conflict");
      chk("conflict_misses", miss_cnt, 3);
      fetch(32'h0000_0043);
      chk_cnt("offset");

      // Address changes while a refill is stalled.
      mem[30'h11] = 32'hAAAA_AAAA;
      fixed_lat   = 2;
      tick();
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h0000_0044;
      m_miss++;
      @(negedge clk);
      chk("mid_miss", bus.ihit, 0);
      tick();
      @(negedge clk);
      chk("mid_iaddr44", bus.iaddr, 32'h0000_0044);
      tick();
      bus.imemaddr = 32'h0000_0100;
      @(negedge clk);
      chk("mid_hold_iren", bus.iREN, 1);
      chk("mid_hold_iaddr", bus.iaddr, 32'h0000_0044);
      tick();
      tick();
      q.push_back(mem_word(30'h40));
      m_miss++;
      @(negedge clk);
      chk("mid_newmiss", bus.ihit, 0);
      tick();
      @(negedge clk);
      chk("mid_iaddr100", bus.iaddr, 32'h0000_0100);
      n = 0;
      while (!bus.ihit && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("mid_lat", n, 3);
      m_hit++;
      resident[1] = 30'h11;
      resident[0] = 30'h40;
      tick();
      bus.imemREN = 1'b0;
      fetch(32'h0000_0044);
      chk_cnt("mid");

      // Flush masks a hit, then abandons a refill answered in the same cycle.
      fetch(32'h0000_0100);
      tick();
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h0000_0100;
      bus.iflush   = 1'b1;
      @(negedge clk);
      chk("flush_masks_hit", bus.ihit, 0);
      tick();
      bus.imemREN = 1'b0;
      bus.iflush  = 1'b0;
      resident.delete();
      chk_cnt("flush_nohit");
      tick();
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h0000_0100;
      m_miss++;
      tick();
      tick();
      tick();
      bus.iflush = 1'b1;
      @(negedge clk);
      chk("flush_ans_iwait", bus.iwait, 0);
      tick();
      bus.iflush  = 1'b0;
      bus.imemREN = 1'b0;
      @(negedge clk);
      chk("flush_iren_drop", bus.iREN, 0);
      fetch(32'h0000_0100);
      chk_cnt("flush_refetch");

      // Randomized traffic with occasional idle flushes.
      fixed_lat = -1;
      for (int i = 0; i < 150; i++) begin
         a = ($urandom_range(0, 63) << 2) | ($urandom & 32'd3);
         fetch(a);
         chk_cnt("rand");
         if ($urandom_range(0, 9) == 0) begin
            tick();
            bus.iflush = 1'b1;
            tick();
            bus.iflush = 1'b0;
            resident.delete();
         end
      end

      // Asynchronous reset between edges during a stalled refill.
      fixed_lat = 6;
      fetch(32'h0000_0040);
      tick();
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h0000_0200;
      tick();
      tick();
      @(negedge clk);
      chk("arst_pre_iren", bus.iREN, 1);
      #2;
      RST = 1'b1;
      #1;
      chk("arst_iren", bus.iREN, 0);
      chk("arst_iaddr", bus.iaddr, 0);
      chk("arst_hits", hit_cnt, 0);
      chk("arst_misses", miss_cnt, 0);
      tick();
      bus.imemREN = 1'b0;
      tick();
      RST = 1'b0;
      m_hit  = 0;
      m_miss = 0;
      resident.delete();
      fixed_lat = 1;
      fetch(32'h0000_0040);
      fetch(32'h0000_0040);
      chk_cnt("arst_after");

      repeat (2) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
